hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters: NREG=32, number of architectural registers; RA_W=$clog2(NREG), register-address width; MAX_OUT=2, maximum outstanding multi-cycle (MDU) writes; TMO_W=8, stall-watchdog counter width.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Port clk  in  1  rising-edge clock.
REQ-004 Port rst_n  in  1  asynchronous active-low reset.
REQ-005 Ports rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E, rd_M, rd_W  in  RA_W each  stage register addresses.
REQ-006 Ports we_reg_D, we_reg_E, we_reg_M, we_reg_W  in  1 each  register-write enables.
REQ-007 Ports is_load_E, is_load_M  in  1 each  instruction in that stage is a load.
REQ-008 Port branch_D  in  1  D-stage instruction is a branch or jump resolved in D.
REQ-009 Port pred_miss_D  in  1  D-stage redirect disagrees with the prediction.
REQ-010 Port mdu_issue_E  in  1  E-stage instruction launches an MDU operation; the target is rd_E.
REQ-011 Ports mdu_done, mdu_rd  in  1, RA_W  MDU result writeback pulse and its destination.
REQ-012 Ports stall_F, stall_D, flush_D, flush_E  out  1 each  pipeline control.
REQ-013 Ports forward_A_D, forward_B_D  out  2 each  encodings 00 none, 01 E, 10 M, 11 W.
REQ-014 Ports forward_A_E, forward_B_E  out  2 each  encodings 00 none, 01 M, 10 W.
REQ-015 Ports mdu_busy  out  1 (outstanding != 0); mdu_full  out  1 (outstanding == MAX_OUT); stall_timeout  out  1  sticky watchdog flag.

Function
REQ-016 Forward priority: nearest stage wins (E>M>W for D; M>W for E). A match requires a nonzero source, an equal rd and that stage's we_reg set.
REQ-017 Scoreboard: one busy bit per register; register 0 is never set.
REQ-018 Busy bit setting: a busy bit sets on the clock edge where mdu_issue_E=1, rd_E!=0 and flush_E=0.
REQ-019 Busy bit clearing: a busy bit clears on the edge where mdu_done=1 for mdu_rd. If set and clear target the same register in the same cycle, set wins.
REQ-020 Outstanding counter: an accepted issue adds +1 and mdu_done subtracts 1; simultaneous issue and done leaves it unchanged. It saturates at 0 and at MAX_OUT and never wraps.
REQ-021 lwStall: is_load_E=1, rd_E!=0, and rs1_D==rd_E or rs2_D==rd_E. The operand match is checked per operand, and only nonzero operands match.
REQ-022 brStall: branch_D=1 and either (a) is_load_M=1 with rd_M matching a nonzero rs of D, or (b) we_reg_E=1 with rd_E matching a nonzero rs of D.
REQ-023 sbStall: a nonzero rs1_D or rs2_D has its busy bit set, or we_reg_D=1 with rd_D busy (WAW).
REQ-024 fullStall: mdu_full=1 and mdu_issue_E=1 with mdu_done=0.
REQ-025 hz = lwStall|brStall|sbStall|fullStall. All stall logic is combinational, with zero-cycle latency.
REQ-026 stall_F = stall_D = hz.
REQ-027 flush_E = hz.
REQ-028 flush_D = pred_miss_D & ~hz.
REQ-029 Watchdog: a TMO_W-bit counter increments while hz=1, saturates at all-ones, and clears when hz=0. stall_timeout sets when the counter reaches all-ones and stays set until reset.

Reset
REQ-030 While rst_n=0: all busy bits 0, outstanding 0, watchdog 0, stall_timeout 0.
REQ-031 Outputs during reset: mdu_busy=0, mdu_full=0. Combinational outputs follow their inputs with an empty scoreboard.
REQ-032 Reset mid-operation discards all outstanding MDU tracking. An mdu_done after reset with no outstanding operation is ignored.

Structure
REQ-033 Shared package hazard_pkg holds:
- forward encodings FWD_D_NONE/E/M/W and FWD_E_NONE/M/W;
- the shared constants for stall causes.
REQ-034 One sub-module, hz_scoreboard, holds the busy bits and the outstanding counter; the top level holds forwarding, stall and watchdog logic.

Verification
REQ-035 Load-use: is_load_E=1, rd_E=5, rs1_D=5 -> stall_F=stall_D=flush_E=1 for one cycle. With rs1_D=0, rs2_D=5, rd_E=0 -> no stall.
REQ-036 MDU RAW: issue with rd_E=7; next cycle rs2_D=7 -> stall held until mdu_done with mdu_rd=7; stall drops the cycle after done.
REQ-037 MAX_OUT=2: two issues, then a third issue with no done -> fullStall=1. A third issue with simultaneous mdu_done -> no stall; outstanding stays 2.
REQ-038 Priority: rd_E=rd_M=rd_W=3, all write enables set, rs1_D=3 -> forward_A_D=01. With we_reg_E=0 -> 10.
REQ-039 Mispredict: pred_miss_D=1 with hz=0 -> flush_D=1. With lwStall active -> flush_D=0.
REQ-040 Watchdog and reset: hz held for 255 cycles (TMO_W=8) -> stall_timeout=1, and it stays 1 after hz drops. Asserting rst_n=0 -> stall_timeout=0 and mdu_busy=0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forwarding encodings and stall-cause indices
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_D_NONE = 2'b00,
        FWD_D_E    = 2'b01,
        FWD_D_M    = 2'b10,
        FWD_D_W    = 2'b11
    } fwd_d_t;

    typedef enum logic [1:0] {
        FWD_E_NONE = 2'b00,
        FWD_E_M    = 2'b01,
        FWD_E_W    = 2'b10
    } fwd_e_t;

    // Bit positions of the individual stall causes within the cause vector.
    localparam int STALL_LW   = 0;
    localparam int STALL_BR   = 1;
    localparam int STALL_SB   = 2;
    localparam int STALL_FULL = 3;
    localparam int N_STALL    = 4;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - pipeline <-> hazard unit signal bundle
interface hazard_scoreboard_if #(
    parameter int NREG = 32,
    parameter int RA_W = $clog2(NREG)
);
    logic [RA_W-1:0] rs1_D, rs2_D, rd_D;
    logic [RA_W-1:0] rs1_E, rs2_E, rd_E;
    logic [RA_W-1:0] rd_M, rd_W;
    logic            we_reg_D, we_reg_E, we_reg_M, we_reg_W;
    logic            is_load_E, is_load_M;
    logic            branch_D, pred_miss_D;
    logic            mdu_issue_E;
    logic            mdu_done;
    logic [RA_W-1:0] mdu_rd;

    logic            stall_F, stall_D, flush_D, flush_E;
    logic [1:0]      forward_A_D, forward_B_D;
    logic [1:0]      forward_A_E, forward_B_E;
    logic            mdu_busy, mdu_full, stall_timeout;

    modport master (
        output rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        output we_reg_D, we_reg_E, we_reg_M, we_reg_W,
        output is_load_E, is_load_M, branch_D, pred_miss_D,
        output mdu_issue_E, mdu_done, mdu_rd,
        input  stall_F, stall_D, flush_D, flush_E,
        input  forward_A_D, forward_B_D, forward_A_E, forward_B_E,
        input  mdu_busy, mdu_full, stall_timeout
    );

    modport slave (
        input  rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        input  we_reg_D, we_reg_E, we_reg_M, we_reg_W,
        input  is_load_E, is_load_M, branch_D, pred_miss_D,
        input  mdu_issue_E, mdu_done, mdu_rd,
        output stall_F, stall_D, flush_D, flush_E,
        output forward_A_D, forward_B_D, forward_A_E, forward_B_E,
        output mdu_busy, mdu_full, stall_timeout
    );
endinterface

// File: rtl/hz_scoreboard.sv
// rtl/hz_scoreboard.sv - per-register MDU busy bits and outstanding-op counter
module hz_scoreboard #(
    parameter int NREG    = 32,
    parameter int RA_W    = $clog2(NREG),
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_en,
    input  logic            set_en,
    input  logic [RA_W-1:0] set_rd,
    input  logic            done_en,
    input  logic [RA_W-1:0] clr_rd,
    output logic [NREG-1:0] busy,
    output logic            mdu_busy,
    output logic            mdu_full
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [NREG-1:0]  busy_nxt;
    logic [CNT_W-1:0] out_cnt;
    logic             inc, dec;

    // Clear is applied before set so a same-register set/clear leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (done_en) busy_nxt[clr_rd] = 1'b0;
        if (set_en)  busy_nxt[set_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // A done with nothing outstanding (e.g. after a reset) is dropped.
    assign inc = issue_en;
    assign dec = done_en && (out_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            out_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            if (inc && !dec && out_cnt != CNT_MAX)
                out_cnt <= out_cnt + CNT_W'(1);
            else if (dec && !inc)
                out_cnt <= out_cnt - CNT_W'(1);
        end
    end

    assign mdu_busy = (out_cnt != '0);
    assign mdu_full = (out_cnt == CNT_MAX);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - forwarding select, stall/flush control and stall watchdog
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int RA_W    = $clog2(NREG),
    parameter int MAX_OUT = 2,
    parameter int TMO_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  hif
);
    logic [NREG-1:0]    busy;
    logic [N_STALL-1:0] cause;
    logic               hz;
    logic               issue_en, set_en;
    logic [TMO_W-1:0]   wd_cnt, wd_nxt;
    logic               timeout_q;

    function automatic logic src_hit(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rd);
        return (rs != '0) && (rs == rd);
    endfunction

    function automatic logic d_hit(input logic [RA_W-1:0] rd);
        return src_hit(hif.rs1_D, rd) || src_hit(hif.rs2_D, rd);
    endfunction

    function automatic logic [1:0] fwd_d(input logic [RA_W-1:0] rs);
        if (hif.we_reg_E && src_hit(rs, hif.rd_E))      return FWD_D_E;
        else if (hif.we_reg_M && src_hit(rs, hif.rd_M)) return FWD_D_M;
        else if (hif.we_reg_W && src_hit(rs, hif.rd_W)) return FWD_D_W;
        else                                            return FWD_D_NONE;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [RA_W-1:0] rs);
        if (hif.we_reg_M && src_hit(rs, hif.rd_M))      return FWD_E_M;
        else if (hif.we_reg_W && src_hit(rs, hif.rd_W)) return FWD_E_W;
        else                                            return FWD_E_NONE;
    endfunction

    assign hif.forward_A_D = fwd_d(hif.rs1_D);
    assign hif.forward_B_D = fwd_d(hif.rs2_D);
    assign hif.forward_A_E = fwd_e(hif.rs1_E);
    assign hif.forward_B_E = fwd_e(hif.rs2_E);

    always_comb begin
        cause             = '0;
        cause[STALL_LW]   = hif.is_load_E && d_hit(hif.rd_E);
        cause[STALL_BR]   = hif.branch_D &&
                            ((hif.is_load_M && d_hit(hif.rd_M)) ||
                             (hif.we_reg_E  && d_hit(hif.rd_E)));
        cause[STALL_SB]   = ((hif.rs1_D != '0) && busy[hif.rs1_D]) ||
                            ((hif.rs2_D != '0) && busy[hif.rs2_D]) ||
                            (hif.we_reg_D && busy[hif.rd_D]);
        cause[STALL_FULL] = hif.mdu_full && hif.mdu_issue_E && !hif.mdu_done;
    end

    assign hz          = |cause;
    assign hif.stall_F = hz;
    assign hif.stall_D = hz;
    assign hif.flush_E = hz;
    assign hif.flush_D = hif.pred_miss_D && !hz;

    // A flushed E-stage issue never reaches the MDU, so it is not tracked.
    assign issue_en = hif.mdu_issue_E && !hz;
    assign set_en   = issue_en && (hif.rd_E != '0);

    hz_scoreboard #(
        .NREG    (NREG),
        .RA_W    (RA_W),
        .MAX_OUT (MAX_OUT)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue_en (issue_en),
        .set_en   (set_en),
        .set_rd   (hif.rd_E),
        .done_en  (hif.mdu_done),
        .clr_rd   (hif.mdu_rd),
        .busy     (busy),
        .mdu_busy (hif.mdu_busy),
        .mdu_full (hif.mdu_full)
    );

    always_comb begin
        wd_nxt = '0;
        if (hz) wd_nxt = (&wd_cnt) ? wd_cnt : wd_cnt + TMO_W'(1);
    end

    // Flag rises on the same edge the counter lands on all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt    <= wd_nxt;
            timeout_q <= timeout_q || (&wd_nxt);
        end
    end

    assign hif.stall_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed stimulus with queued expectations checked by a monitor
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(32)) hif ();

    hazard_scoreboard #(.NREG(32), .MAX_OUT(2), .TMO_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif)
    );

    localparam int O_SF = 0, O_SD = 1, O_FD = 2, O_FE = 3, O_AD = 4, O_BD = 5;
    localparam int O_AE = 6, O_BE = 7, O_BUSY = 8, O_FULL = 9, O_TMO = 10;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] v;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [7:0] get_out(input int sel);
        case (sel)
            O_SF:    return 8'(hif.stall_F);
            O_SD:    return 8'(hif.stall_D);
            O_FD:    return 8'(hif.flush_D);
            O_FE:    return 8'(hif.flush_E);
            O_AD:    return 8'(hif.forward_A_D);
            O_BD:    return 8'(hif.forward_B_D);
            O_AE:    return 8'(hif.forward_A_E);
            O_BE:    return 8'(hif.forward_B_E);
            O_BUSY:  return 8'(hif.mdu_busy);
            O_FULL:  return 8'(hif.mdu_full);
            default: return 8'(hif.stall_timeout);
        endcase
    endfunction

    task automatic expect_out(input string name, input int sel, input int v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.v    = 8'(v);
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hif.rs1_D = '0; hif.rs2_D = '0; hif.rd_D = '0;
        hif.rs1_E = '0; hif.rs2_E = '0; hif.rd_E = '0;
        hif.rd_M = '0; hif.rd_W = '0;
        hif.we_reg_D = 0; hif.we_reg_E = 0; hif.we_reg_M = 0; hif.we_reg_W = 0;
        hif.is_load_E = 0; hif.is_load_M = 0;
        hif.branch_D = 0; hif.pred_miss_D = 0;
        hif.mdu_issue_E = 0; hif.mdu_done = 0; hif.mdu_rd = '0;
    endtask

    // Monitor: drains pending expectations mid-cycle, away from the active edge.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = get_out(e.sel);
                n_checks++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %0d expected %0d", e.name, act, e.v);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        expect_out("rst_mdu_busy", O_BUSY, 0);
        expect_out("rst_mdu_full", O_FULL, 0);
        expect_out("rst_timeout", O_TMO, 0);
        expect_out("rst_stall_F", O_SF, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // load-use
        idle(); hif.is_load_E = 1; hif.rd_E = 5; hif.rs1_D = 5;
        expect_out("lw_stall_F", O_SF, 1);
        expect_out("lw_stall_D", O_SD, 1);
        expect_out("lw_flush_E", O_FE, 1);
        expect_out("lw_flush_D", O_FD, 0);
        tick();
        idle();
        expect_out("lw_one_cycle", O_SF, 0);
        tick();
        idle(); hif.is_load_E = 1; hif.rd_E = 0; hif.rs1_D = 0; hif.rs2_D = 5;
        expect_out("lw_rd0_nostall", O_SF, 0);
        tick();

        // forwarding priority
        idle(); hif.rd_E = 3; hif.rd_M = 3; hif.rd_W = 3;
        hif.we_reg_E = 1; hif.we_reg_M = 1; hif.we_reg_W = 1;
        hif.rs1_D = 3; hif.rs1_E = 3;
        expect_out("fwd_A_D_E", O_AD, 1);
        expect_out("fwd_B_D_zero", O_BD, 0);
        expect_out("fwd_A_E_M", O_AE, 1);
        expect_out("fwd_no_stall", O_SF, 0);
        tick();
        hif.we_reg_E = 0;
        expect_out("fwd_A_D_M", O_AD, 2);
        tick();
        hif.we_reg_M = 0; hif.rs2_E = 3;
        expect_out("fwd_A_D_W", O_AD, 3);
        expect_out("fwd_A_E_W", O_AE, 2);
        expect_out("fwd_B_E_W", O_BE, 2);
        tick();

        // mispredict
        idle(); hif.pred_miss_D = 1;
        expect_out("miss_flush_D", O_FD, 1);
        tick();
        hif.is_load_E = 1; hif.rd_E = 4; hif.rs2_D = 4;
        expect_out("miss_lw_flush_D", O_FD, 0);
        expect_out("miss_lw_stall", O_SF, 1);
        tick();

        // branch in D
        idle(); hif.branch_D = 1; hif.we_reg_E = 1; hif.rd_E = 6; hif.rs1_D = 6;
        expect_out("br_alu_stall", O_SD, 1);
        tick();
        idle(); hif.branch_D = 1; hif.is_load_M = 1; hif.rd_M = 9; hif.rs2_D = 9;
        expect_out("br_load_stall", O_SD, 1);
        tick();
        hif.branch_D = 0;
        expect_out("nobr_no_stall", O_SD, 0);
        tick();

        // MDU RAW / WAW
        idle(); hif.mdu_issue_E = 1; hif.rd_E = 7;
        expect_out("mdu_issue_flush_E", O_FE, 0);
        expect_out("mdu_pre_busy", O_BUSY, 0);
        tick();
        idle(); hif.rs2_D = 7;
        expect_out("raw_stall", O_SD, 1);
        expect_out("raw_mdu_busy", O_BUSY, 1);
        expect_out("raw_mdu_full", O_FULL, 0);
        tick();
        idle(); hif.we_reg_D = 1; hif.rd_D = 7;
        expect_out("waw_stall", O_SF, 1);
        tick();
        idle(); hif.rs2_D = 7; hif.mdu_done = 1; hif.mdu_rd = 7;
        expect_out("raw_done_cycle", O_SD, 1);
        tick();
        idle(); hif.rs2_D = 7;
        expect_out("raw_released", O_SD, 0);
        expect_out("raw_idle_busy", O_BUSY, 0);
        tick();

        // outstanding limit
        idle(); hif.mdu_issue_E = 1; hif.rd_E = 10;
        expect_out("full_first", O_FULL, 0);
        tick();
        idle(); hif.mdu_issue_E = 1; hif.rd_E = 11;
        tick();
        idle(); hif.mdu_issue_E = 1; hif.rd_E = 12;
        expect_out("full_flag", O_FULL, 1);
        expect_out("full_stall", O_SF, 1);
        expect_out("full_flush_E", O_FE, 1);
        tick();
        idle(); hif.mdu_issue_E = 1; hif.rd_E = 12; hif.mdu_done = 1; hif.mdu_rd = 10;
        expect_out("full_done_nostall", O_SF, 0);
        expect_out("full_done_flush_E", O_FE, 0);
        tick();
        idle(); hif.rs1_D = 12;
        expect_out("full_still_two", O_FULL, 1);
        expect_out("sb_r12_busy", O_SF, 1);
        tick();
        idle(); hif.rs1_D = 10;
        expect_out("sb_r10_cleared", O_SF, 0);
        tick();

        // watchdog
        idle(); hif.rs1_D = 11;
        repeat (254) tick();
        expect_out("wd_254_clear", O_TMO, 0);
        tick();
        expect_out("wd_255_set", O_TMO, 1);
        tick();
        idle();
        expect_out("wd_sticky", O_TMO, 1);
        expect_out("wd_hz_dropped", O_SF, 0);
        tick();

        // asynchronous reset mid-operation
        hif.rs1_D = 11;
        rst_n = 1'b0;
        #1;
        expect_out("arst_timeout", O_TMO, 0);
        expect_out("arst_mdu_busy", O_BUSY, 0);
        expect_out("arst_mdu_full", O_FULL, 0);
        expect_out("arst_sb_empty", O_SF, 0);
        tick();
        rst_n = 1'b1;
        idle(); hif.mdu_done = 1; hif.mdu_rd = 5;
        tick();
        idle();
        expect_out("stray_done_busy", O_BUSY, 0);
        hif.mdu_issue_E = 1; hif.rd_E = 5;
        tick();
        idle(); hif.rs1_D = 5;
        expect_out("post_rst_busy", O_BUSY, 1);
        expect_out("post_rst_full", O_FULL, 0);
        expect_out("post_rst_stall", O_SF, 1);
        tick();
        idle();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
